// File: rtl/rbr_add_subb_pipe.sv
// rtl/rbr_add_subb_pipe.sv - pipelined carry-free RBR adder/subtractor with valid/ready flow control
// Digit cells feed stage 0; later stages are elastic delay stages that stall from the output backward.
module rbr_add_subb_pipe #(
   parameter int W   = 64,
   parameter int LAT = 2
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             subb_a,
   input  logic             subb_b,
   input  logic [2*W-1:0]   a,
   input  logic [2*W-1:0]   b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W+1:0]   s,
   output logic             out_zero
);

   localparam int SW = 2*W+2;

   logic [2*W-1:0] a_n, b_n;
   logic [SW-1:0]  sum_c;
   logic           zero_c;
   logic           hp, gp;
   logic [1:0]     fa1, fa2;
   logic [W:0]     dig_hi, dig_lo;
   logic [W+1:0]   pos_sum;

   // h/g ripple only one digit, so the cell delay is independent of W.
   always_comb begin
      a_n    = subb_a ? ~a : a;
      b_n    = subb_b ? ~b : b;
      sum_c  = '0;
      hp     = 1'b1;
      gp     = 1'b0;
      fa1    = '0;
      fa2    = '0;
      for (int i = 0; i < W; i++) begin
         fa1 = {1'b0, a_n[2*i+1]} + {1'b0, a_n[2*i]} + {1'b0, b_n[2*i+1]};
         fa2 = {1'b0, fa1[0]} + {1'b0, b_n[2*i]} + {1'b0, hp};
         sum_c[2*i+1] = fa2[0];
         sum_c[2*i]   = gp;
         hp = fa1[1];
         gp = fa2[1];
      end
      sum_c[2*W+1] = hp;
      sum_c[2*W]   = gp;
   end

   // value(s) = X + Y - (2^(W+1)-1), with X/Y the upper/lower digit bits read as binary.
   always_comb begin
      dig_hi = '0;
      dig_lo = '0;
      for (int i = 0; i <= W; i++) begin
         dig_hi[i] = sum_c[2*i+1];
         dig_lo[i] = sum_c[2*i];
      end
      pos_sum = {1'b0, dig_hi} + {1'b0, dig_lo};
      zero_c  = (pos_sum == {1'b0, {(W+1){1'b1}}});
   end

   logic [LAT-1:0] v_q, v_d, adv;
   logic [LAT-1:0] z_q, z_d;
   logic [SW-1:0]  s_q [LAT];
   logic [SW-1:0]  s_d [LAT];
   logic           accept;
   logic           down_full;

   // A stage moves if the output drains or any later stage holds a bubble.
   always_comb begin
      adv       = '0;
      down_full = 1'b1;
      for (int k = 0; k < LAT; k++) begin
         down_full = 1'b1;
         for (int j = k + 1; j < LAT; j++) begin
            down_full = down_full & v_q[j];
         end
         adv[k] = v_q[k] & (out_ready | ~down_full);
      end
   end

   always_comb begin
      in_ready = ~v_q[0] | adv[0];
      accept   = in_valid & in_ready;
      v_d      = v_q;
      z_d      = z_q;
      s_d      = s_q;
      v_d[0]   = accept | (v_q[0] & ~adv[0]);
      if (accept) begin
         s_d[0] = sum_c;
         z_d[0] = zero_c;
      end
      for (int k = 1; k < LAT; k++) begin
         v_d[k] = adv[k-1] | (v_q[k] & ~adv[k]);
         if (adv[k-1]) begin
            s_d[k] = s_q[k-1];
            z_d[k] = z_q[k-1];
         end
      end
      if (flush) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         v_q <= '0;
         z_q <= '1;
         for (int k = 0; k < LAT; k++) begin
            s_q[k] <= {(W+1){2'b01}};
         end
      end else begin
         v_q <= v_d;
         z_q <= z_d;
         s_q <= s_d;
      end
   end

   assign out_valid = v_q[LAT-1];
   assign s         = s_q[LAT-1];
   assign out_zero  = z_q[LAT-1];

endmodule
